gen_mdio_write_logic: RTL and testbench

GEN_MDIO_WRITE_LOGIC -- requirements
Module: gen_mdio_write_logic

---
 rtl/gen_mdio_write_logic.sv | 140 ++++++++++++++
 tb/tb_gen_mdio_write_logic.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_mdio_write_logic.sv
// MDIO write fan-out: one request becomes a one-cycle chip enable on a single
// capture memory, optionally stepping an internal (sel, addr) pointer.
module gen_mdio_write_logic #(
  parameter int NUM_MEM = 96
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    mdio_wr_en,
  input  logic                    rf_mdio_write_en,
  input  logic                    rf_mdio_ptr_load,
  input  logic                    rf_mdio_auto_inc,
  input  logic [6:0]              rf_mdio_which_memory_sel,
  input  logic [14:0]             rf_mdio_memory_addr,
  input  logic [8:0]              rf_mdio_wr_data,
  output logic [NUM_MEM-1:0]      mdio_wr_chip_en,
  output logic [NUM_MEM*15-1:0]   mdio_wr_waddr,
  output logic [NUM_MEM*9-1:0]    mdio_wr_wdata,
  output logic                    mdio_wr_busy,
  output logic                    mdio_wr_err,
  output logic                    mdio_wr_done
);

  localparam logic [6:0]  LAST_SEL  = 7'(NUM_MEM - 1);
  localparam logic [14:0] LAST_ADDR = 15'h7fff;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_RECOVER
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_MEM-1:0] r_chip_en;
  logic [6:0]         r_sel;
  logic [14:0]        r_addr;
  logic [8:0]         r_data;
  logic               r_auto;
  logic [6:0]         r_ptr_sel;
  logic [14:0]        r_ptr_addr;
  logic               r_err;
  logic               r_done;

  logic [6:0]         w_tgt_sel;
  logic [14:0]        w_tgt_addr;
  logic [NUM_MEM-1:0] w_onehot;
  logic               w_req;
  logic               w_accept;
  logic               w_req_err;
  logic               w_load;
  logic               w_load_ok;
  logic               w_load_err;
  logic               w_inc;
  logic               w_last;
  logic [6:0]         w_inc_sel;
  logic [14:0]        w_inc_addr;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_sel   = rf_mdio_auto_inc ? r_ptr_sel : rf_mdio_which_memory_sel;
    w_tgt_addr  = rf_mdio_auto_inc ? r_ptr_addr : rf_mdio_memory_addr;
    w_req       = mdio_wr_en & rf_mdio_write_en;
    w_accept    = w_req && (r_state == S_IDLE) && (w_tgt_sel <= LAST_SEL);
    w_req_err   = w_req && !w_accept;
    w_load      = mdio_wr_en & rf_mdio_ptr_load;
    w_load_ok   = w_load && (rf_mdio_which_memory_sel <= LAST_SEL);
    w_load_err  = w_load && !w_load_ok;
    w_inc       = mdio_wr_en && (r_state == S_WRITE) && r_auto;
    w_last      = mdio_wr_en && (r_state == S_WRITE) &&
                  (r_sel == LAST_SEL) && (r_addr == LAST_ADDR);
    w_inc_addr  = r_ptr_addr + 15'd1;
    w_inc_sel   = r_ptr_sel;
    if (r_ptr_addr == LAST_ADDR)
      w_inc_sel = (r_ptr_sel == LAST_SEL) ? 7'd0 : r_ptr_sel + 7'd1;

    unique case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_WRITE;
      S_WRITE:   w_state_nxt = S_RECOVER;
      S_RECOVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (!mdio_wr_en) w_state_nxt = S_IDLE;

    w_onehot      = '0;
    mdio_wr_waddr = '0;
    mdio_wr_wdata = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      w_onehot[i] = (w_tgt_sel == 7'(i));
      if (r_state == S_WRITE && r_sel == 7'(i)) begin
        mdio_wr_waddr[i*15 +: 15] = r_addr;
        mdio_wr_wdata[i*9 +: 9]   = r_data;
      end
    end
    mdio_wr_chip_en = r_chip_en;
    mdio_wr_busy    = (r_state != S_IDLE);
    mdio_wr_err     = r_err;
    mdio_wr_done    = r_done;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_chip_en  <= '0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_auto     <= 1'b0;
      r_ptr_sel  <= '0;
      r_ptr_addr <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_chip_en <= w_accept ? w_onehot : '0;
      if (w_accept) begin
        r_sel  <= w_tgt_sel;
        r_addr <= w_tgt_addr;
        r_data <= rf_mdio_wr_data;
        r_auto <= rf_mdio_auto_inc;
      end
      // An explicit load overrides the post-write step
      if (w_load_ok) begin
        r_ptr_sel  <= rf_mdio_which_memory_sel;
        r_ptr_addr <= rf_mdio_memory_addr;
      end else if (w_inc) begin
        r_ptr_sel  <= w_inc_sel;
        r_ptr_addr <= w_inc_addr;
      end
      if (!mdio_wr_en)                 r_err <= 1'b0;
      else if (w_req_err || w_load_err) r_err <= 1'b1;
      if (!mdio_wr_en)  r_done <= 1'b0;
      else if (w_last)  r_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gen_mdio_write_logic.sv
// Scoreboard bench for gen_mdio_write_logic: expected writes are queued
// as requests are driven and matched against chip enables on the buses.
module tb_gen_mdio_write_logic;

  localparam int N = 96;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           mdio_wr_en = 1'b0;
  logic           rf_mdio_write_en = 1'b0;
  logic           rf_mdio_ptr_load = 1'b0;
  logic           rf_mdio_auto_inc = 1'b0;
  logic [6:0]     rf_mdio_which_memory_sel = '0;
  logic [14:0]    rf_mdio_memory_addr = '0;
  logic [8:0]     rf_mdio_wr_data = '0;
  logic [N-1:0]   mdio_wr_chip_en;
  logic [N*15-1:0] mdio_wr_waddr;
  logic [N*9-1:0] mdio_wr_wdata;
  logic           mdio_wr_busy;
  logic           mdio_wr_err;
  logic           mdio_wr_done;

  typedef struct packed {
    logic [6:0]  sel;
    logic [14:0] addr;
    logic [8:0]  data;
  } txn_t;

  txn_t q[$];
  int total = 0;
  int bad = 0;

  gen_mdio_write_logic #(.NUM_MEM(N)) dut (
    .clk(clk),
    .rstn(rstn),
    .mdio_wr_en(mdio_wr_en),
    .rf_mdio_write_en(rf_mdio_write_en),
    .rf_mdio_ptr_load(rf_mdio_ptr_load),
    .rf_mdio_auto_inc(rf_mdio_auto_inc),
    .rf_mdio_which_memory_sel(rf_mdio_which_memory_sel),
    .rf_mdio_memory_addr(rf_mdio_memory_addr),
    .rf_mdio_wr_data(rf_mdio_wr_data),
    .mdio_wr_chip_en(mdio_wr_chip_en),
    .mdio_wr_waddr(mdio_wr_waddr),
    .mdio_wr_wdata(mdio_wr_wdata),
    .mdio_wr_busy(mdio_wr_busy),
    .mdio_wr_err(mdio_wr_err),
    .mdio_wr_done(mdio_wr_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [N-1:0]    ce;
    logic [N*15-1:0] wa;
    logic [N*9-1:0]  wd;
    txn_t e;
    if (mdio_wr_chip_en !== '0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write chip_en got nonzero required none at %0t", $time);
      end else begin
        e = q.pop_front();
        ce = '0;
        wa = '0;
        wd = '0;
        ce[e.sel] = 1'b1;
        wa[e.sel*15 +: 15] = e.addr;
        wd[e.sel*9 +: 9] = e.data;
        total += 2;
        if (mdio_wr_chip_en !== ce) begin
          bad++;
          $display("FAIL chip_en sel=%0d got_bit=%b", e.sel, mdio_wr_chip_en[e.sel]);
        end
        if (mdio_wr_waddr !== wa) begin
          bad++;
          $display("FAIL waddr sel=%0d got=%h required=%h",
                   e.sel, mdio_wr_waddr[e.sel*15 +: 15], e.addr);
        end
        if (mdio_wr_wdata !== wd) begin
          bad++;
          $display("FAIL wdata sel=%0d got=%h required=%h",
                   e.sel, mdio_wr_wdata[e.sel*9 +: 9], e.data);
        end
      end
    end else if (mdio_wr_waddr !== '0 || mdio_wr_wdata !== '0) begin
      total++;
      bad++;
      $display("FAIL stray_bus waddr/wdata nonzero without chip_en at %0t", $time);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [6:0] s, input logic [14:0] a,
                          input logic [8:0] d, input logic au);
    rf_mdio_which_memory_sel = s;
    rf_mdio_memory_addr = a;
    rf_mdio_wr_data = d;
    rf_mdio_auto_inc = au;
    rf_mdio_write_en = 1'b1;
    cyc();
    rf_mdio_write_en = 1'b0;
  endtask

  task automatic load_ptr(input logic [6:0] s, input logic [14:0] a);
    rf_mdio_which_memory_sel = s;
    rf_mdio_memory_addr = a;
    rf_mdio_ptr_load = 1'b1;
    cyc();
    rf_mdio_ptr_load = 1'b0;
  endtask

  task automatic chk(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b required=%b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cyc();
    cyc();
    total++;
    if (mdio_wr_chip_en !== '0 || mdio_wr_waddr !== '0 || mdio_wr_wdata !== '0) begin
      bad++;
      $display("FAIL reset_buses got nonzero required zero");
    end
    chk("reset_busy", mdio_wr_busy, 1'b0);
    chk("reset_err", mdio_wr_err, 1'b0);
    chk("reset_done", mdio_wr_done, 1'b0);
    rstn = 1'b1;
    mdio_wr_en = 1'b1;
    cyc();
  endtask

  task automatic test_direct();
    q.push_back('{7'd5, 15'h0123, 9'h1A5});
    drive_wr(7'd5, 15'h0123, 9'h1A5, 1'b0);
    chk("direct_busy_w", mdio_wr_busy, 1'b1);
    chk("direct_ce5", mdio_wr_chip_en[5], 1'b1);
    cyc();
    chk("direct_busy_r", mdio_wr_busy, 1'b1);
    chk("direct_ce_off", mdio_wr_chip_en[5], 1'b0);
    cyc();
    chk("direct_idle", mdio_wr_busy, 1'b0);
    chk("direct_err", mdio_wr_err, 1'b0);
  endtask

  task automatic test_busy_collision();
    q.push_back('{7'd7, 15'h0010, 9'h002});
    drive_wr(7'd7, 15'h0010, 9'h002, 1'b0);
    drive_wr(7'd8, 15'h0020, 9'h003, 1'b0);
    chk("coll_err", mdio_wr_err, 1'b1);
    cyc();
    chk("coll_idle", mdio_wr_busy, 1'b0);
    chk("coll_err_sticky", mdio_wr_err, 1'b1);
    mdio_wr_en = 1'b0;
    cyc();
    chk("coll_err_clr", mdio_wr_err, 1'b0);
    mdio_wr_en = 1'b1;
  endtask

  task automatic test_auto_wrap();
    load_ptr(7'd3, 15'h7FFF);
    q.push_back('{7'd3, 15'h7FFF, 9'h0AA});
    drive_wr(7'd50, 15'h1234, 9'h0AA, 1'b1);
    cyc();
    cyc();
    q.push_back('{7'd4, 15'h0000, 9'h055});
    drive_wr(7'd50, 15'h1234, 9'h055, 1'b1);
    cyc();
    cyc();
  endtask

  task automatic test_done();
    q.push_back('{7'd95, 15'h7FFF, 9'h1FF});
    drive_wr(7'd95, 15'h7FFF, 9'h1FF, 1'b0);
    chk("done_early", mdio_wr_done, 1'b0);
    cyc();
    chk("done_set", mdio_wr_done, 1'b1);
    cyc();
    chk("done_hold", mdio_wr_done, 1'b1);
    load_ptr(7'd95, 15'h7FFF);
    q.push_back('{7'd95, 15'h7FFF, 9'h011});
    drive_wr(7'd0, 15'h0, 9'h011, 1'b1);
    cyc();
    cyc();
    q.push_back('{7'd0, 15'h0000, 9'h022});
    drive_wr(7'd9, 15'h9, 9'h022, 1'b1);
    cyc();
    cyc();
    chk("done_sticky", mdio_wr_done, 1'b1);
    drive_wr(7'd96, 15'h0001, 9'h033, 1'b0);
    chk("sel96_err", mdio_wr_err, 1'b1);
    chk("sel96_nobusy", mdio_wr_busy, 1'b0);
    cyc();
    mdio_wr_en = 1'b0;
    cyc();
    chk("done_clr", mdio_wr_done, 1'b0);
    chk("err_clr", mdio_wr_err, 1'b0);
    mdio_wr_en = 1'b1;
  endtask

  task automatic test_bad_load();
    load_ptr(7'd120, 15'h0055);
    chk("badload_err", mdio_wr_err, 1'b1);
    mdio_wr_en = 1'b0;
    cyc();
    mdio_wr_en = 1'b1;
    q.push_back('{7'd0, 15'h0001, 9'h044});
    drive_wr(7'd0, 15'h0, 9'h044, 1'b1);
    cyc();
    cyc();
  endtask

  task automatic test_ignore_disabled();
    mdio_wr_en = 1'b0;
    cyc();
    drive_wr(7'd9, 15'h0009, 9'h009, 1'b0);
    load_ptr(7'd40, 15'h0040);
    load_ptr(7'd120, 15'h0040);
    chk("dis_err", mdio_wr_err, 1'b0);
    chk("dis_busy", mdio_wr_busy, 1'b0);
    mdio_wr_en = 1'b1;
    q.push_back('{7'd0, 15'h0002, 9'h066});
    drive_wr(7'd0, 15'h0, 9'h066, 1'b1);
    cyc();
    cyc();
  endtask

  task automatic test_load_precedence();
    q.push_back('{7'd0, 15'h0003, 9'h077});
    drive_wr(7'd0, 15'h0, 9'h077, 1'b1);
    load_ptr(7'd20, 15'h0300);
    cyc();
    q.push_back('{7'd20, 15'h0300, 9'h088});
    drive_wr(7'd0, 15'h0, 9'h088, 1'b1);
    cyc();
    cyc();
  endtask

  task automatic test_abort();
    q.push_back('{7'd10, 15'h0100, 9'h010});
    drive_wr(7'd10, 15'h0100, 9'h010, 1'b0);
    mdio_wr_en = 1'b0;
    cyc();
    chk("abort_busy", mdio_wr_busy, 1'b0);
    chk("abort_ce", mdio_wr_chip_en[10], 1'b0);
    mdio_wr_en = 1'b1;
    q.push_back('{7'd11, 15'h0110, 9'h011});
    drive_wr(7'd11, 15'h0110, 9'h011, 1'b0);
    chk("abort_next_ce", mdio_wr_chip_en[11], 1'b1);
    cyc();
    cyc();
    q.push_back('{7'd12, 15'h0120, 9'h012});
    drive_wr(7'd12, 15'h0120, 9'h012, 1'b0);
    rstn = 1'b0;
    cyc();
    chk("rst_busy", mdio_wr_busy, 1'b0);
    chk("rst_ce", mdio_wr_chip_en[12], 1'b0);
    rstn = 1'b1;
    q.push_back('{7'd0, 15'h0000, 9'h0F0});
    drive_wr(7'd33, 15'h0333, 9'h0F0, 1'b1);
    chk("rst_next_busy", mdio_wr_busy, 1'b1);
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      q.push_back('{7'(60 + i), 15'(16'h4000 + i), 9'(9'h100 + i)});
      drive_wr(7'(60 + i), 15'(16'h4000 + i), 9'(9'h100 + i), 1'b0);
      cyc();
      cyc();
    end
    chk("b2b_err", mdio_wr_err, 1'b0);
    cyc();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d pending required=0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_direct();
    test_busy_collision();
    test_auto_wrap();
    test_done();
    test_bad_load();
    test_ignore_disabled();
    test_load_precedence();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
